i2s_tx_multiline: RTL and testbench

//  Synthesizable multi-line I2S transmitter for DAC slots: bck/lrck master plus NUM_LINES sdata lines.

---
 rtl/i2s_tx_multiline.sv | 111 +++++++++++
 tb/tb_i2s_tx_multiline.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_multiline.sv
// i2s_tx_multiline: I2S master driving NUM_LINES sdata lines from one bck/lrck pair.
// A one-frame holding register feeds per-line frame shift registers loaded at each frame boundary.
module i2s_tx_multiline #(
    parameter int NUM_LINES    = 4,
    parameter int SAMPLE_WIDTH = 24,
    parameter int SLOT_BITS    = 32,
    parameter int BCK_DIV      = 2
) (
    input  logic                                mclk,
    input  logic                                reset_n,
    input  logic                                enable,
    input  logic                                wide_mode,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [2*NUM_LINES*SAMPLE_WIDTH-1:0] in_data,
    output logic                                bck,
    output logic                                lrck,
    output logic [NUM_LINES-1:0]                sdata,
    output logic                                underflow,
    output logic [15:0]                         underflow_count
);
    localparam int FW = 2 * SLOT_BITS;
    localparam int DW = BCK_DIV > 1 ? $clog2(BCK_DIV) : 1;
    localparam int BW = $clog2(FW);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                              r_state, w_next;
    logic [DW-1:0]                       r_div;
    logic [BW-1:0]                       r_bit, w_bit_nxt;
    logic                                r_bck, r_lrck, r_underflow, r_hold_valid;
    logic [NUM_LINES-1:0]                r_sdata;
    logic [15:0]                         r_uf_cnt;
    logic [2*NUM_LINES*SAMPLE_WIDTH-1:0] r_hold;
    logic [FW-1:0]                       r_shift [NUM_LINES];
    logic [FW-1:0]                       w_frame [NUM_LINES];
    logic                                w_tick, w_fall, w_wrap, w_commit, w_accept;

    assign in_ready        = !r_hold_valid;
    assign bck             = r_bck;
    assign lrck            = r_lrck;
    assign sdata           = r_sdata;
    assign underflow       = r_underflow;
    assign underflow_count = r_uf_cnt;

    always_comb begin
        w_tick    = r_state == S_RUN && r_div == DW'(BCK_DIV - 1);
        w_fall    = w_tick && r_bck;
        w_wrap    = w_fall && r_bit == BW'(FW - 1);
        w_commit  = enable && (r_state == S_IDLE || w_wrap);
        w_accept  = in_valid && !r_hold_valid;
        w_bit_nxt = (r_bit == BW'(FW - 1)) ? '0 : r_bit + 1'b1;
        w_next    = (r_state == S_IDLE) ? (enable ? S_RUN : S_IDLE)
                                        : ((w_wrap && !enable) ? S_IDLE : S_RUN);
    end

    // Each line's frame image is L then R, each left-justified in its slot with zero padding.
    always_comb begin
        for (int i = 0; i < NUM_LINES; i++)
            w_frame[i] = (r_hold_valid && (wide_mode || i == 0))
                ? (FW'(r_hold[(2*i+1)*SAMPLE_WIDTH-1 -: SAMPLE_WIDTH]) << (FW - SAMPLE_WIDTH))
                  | (FW'(r_hold[(2*i+2)*SAMPLE_WIDTH-1 -: SAMPLE_WIDTH]) << (SLOT_BITS - SAMPLE_WIDTH))
                : '0;
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_div        <= '0;
            r_bit        <= '0;
            r_bck        <= 1'b0;
            r_lrck       <= 1'b0;
            r_sdata      <= '0;
            r_underflow  <= 1'b0;
            r_uf_cnt     <= '0;
            r_hold_valid <= 1'b0;
            r_hold       <= '0;
            for (int i = 0; i < NUM_LINES; i++) r_shift[i] <= '0;
        end else begin
            r_state     <= w_next;
            r_underflow <= w_commit && !r_hold_valid;
            if (w_commit && !r_hold_valid && r_uf_cnt != 16'hFFFF) r_uf_cnt <= r_uf_cnt + 1'b1;
            if (w_accept) begin
                r_hold_valid <= 1'b1;
                r_hold       <= in_data;
            end else if (w_commit) begin
                r_hold_valid <= 1'b0;
            end
            if (w_next == S_IDLE || r_state == S_IDLE) begin
                r_div   <= '0;
                r_bit   <= '0;
                r_bck   <= 1'b0;
                r_lrck  <= 1'b0;
                r_sdata <= '0;
            end else begin
                r_div <= w_tick ? '0 : r_div + 1'b1;
                r_bck <= r_bck ^ w_tick;
                // The bit leaving the shift register at the wrap is the last R bit of the old frame.
                if (w_fall) begin
                    r_bit  <= w_bit_nxt;
                    r_lrck <= int'(w_bit_nxt) >= SLOT_BITS;
                    for (int i = 0; i < NUM_LINES; i++) r_sdata[i] <= r_shift[i][FW-1];
                end
            end
            for (int i = 0; i < NUM_LINES; i++) begin
                if (w_commit) r_shift[i] <= w_frame[i];
                else if (w_fall) r_shift[i] <= r_shift[i] << 1;
            end
        end
    end
endmodule

// File: tb/tb_i2s_tx_multiline.sv
// tb_i2s_tx_multiline: a frame-timing model queues the expected frame at every commit; an I2S
// receiver reassembles each line on bck rises and checks it against the queued frame.
module tb_i2s_tx_multiline;
    localparam int NL = 4, SW = 24, SB = 32, BD = 2;
    localparam int FB = 2 * SB, FC = FB * 2 * BD, DWID = 2 * NL * SW;

    logic            mclk = 0, reset_n = 1, enable = 0, wide_mode = 0, in_valid = 0;
    logic [DWID-1:0] in_data = '0;
    logic            in_ready, bck, lrck, underflow;
    logic [NL-1:0]   sdata;
    logic [15:0]     underflow_count;

    int total = 0, bad = 0;

    i2s_tx_multiline #(.NUM_LINES(NL), .SAMPLE_WIDTH(SW), .SLOT_BITS(SB), .BCK_DIV(BD)) dut (
        .mclk(mclk), .reset_n(reset_n), .enable(enable), .wide_mode(wide_mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .bck(bck), .lrck(lrck),
        .sdata(sdata), .underflow(underflow), .underflow_count(underflow_count)
    );

    always #5 mclk = ~mclk;

    function automatic logic [DWID-1:0] mk(input logic [SW-1:0] l, input logic [SW-1:0] r,
                                           input logic [SW-1:0] step);
        logic [DWID-1:0] d;
        d = '0;
        for (int n = 0; n < NL; n++) begin
            d[(2*n+1)*SW-1 -: SW] = l + SW'(n) * step;
            d[(2*n+2)*SW-1 -: SW] = r + SW'(n) * step;
        end
        return d;
    endfunction

    function automatic logic [NL*FB-1:0] expect_frame(input logic [DWID-1:0] d, input logic w);
        logic [NL*FB-1:0] e;
        e = '0;
        for (int n = 0; n < NL; n++)
            if (w || n == 0)
                e[n*FB +: FB] = {d[(2*n+1)*SW-1 -: SW], {(SB-SW){1'b0}},
                                 d[(2*n+2)*SW-1 -: SW], {(SB-SW){1'b0}}};
        return e;
    endfunction

    // Reference model: frame boundaries every FC mclk after the start edge, holding register, underflows.
    bit               m_run, m_hv, m_ufp, m_acc, m_com;
    int               m_cyc, m_uf;
    logic [DWID-1:0]  m_hd;
    logic [NL*FB-1:0] q[$];

    always @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            m_run = 0; m_cyc = 0; m_hv = 0; m_ufp = 0; m_uf = 0;
            q.delete();
        end else begin
            m_acc = in_valid && !m_hv;
            m_com = 0;
            if (!m_run) begin
                if (enable) begin m_com = 1; m_run = 1; m_cyc = 0; end
            end else if (m_cyc == FC - 1) begin
                m_cyc = 0; m_com = enable; m_run = enable;
            end else begin
                m_cyc++;
            end
            m_ufp = m_com && !m_hv;
            if (m_com) begin
                q.push_back(m_hv ? expect_frame(m_hd, wide_mode) : '0);
                if (!m_hv) m_uf++;
                m_hv = 0;
            end
            if (m_acc) begin m_hv = 1; m_hd = in_data; end
        end
    end

    // Receiver: bit k of a frame is sampled on the k-th bck rise after the start edge.
    int               rx_b, rx_cnt, err_fr, err_ctl, frames, obs_uf;
    bit               rx_have, rx_pb;
    logic [FB-1:0]    rx [NL];
    logic [NL*FB-1:0] rx_got, rx_exp;

    always @(negedge mclk) begin
        if (underflow === 1'b1) obs_uf++;
        if (in_ready !== !m_hv || underflow !== m_ufp || underflow_count !== 16'(m_uf)) err_ctl++;
        if (!m_run) begin
            rx_b = 0; rx_have = 0; rx_pb = 0;
        end else begin
            rx_cnt++;
            if (bck === 1'b1 && !rx_pb) begin
                if (rx_have && rx_cnt != 2 * BD) err_fr++;
                rx_have = 1; rx_cnt = 0;
                if (lrck !== (rx_b >= SB)) err_fr++;
                if (rx_b == 0) begin
                    if (sdata !== '0) err_fr++;
                end else begin
                    for (int i = 0; i < NL; i++) rx[i][FB-rx_b] = sdata[i];
                end
                if (rx_b == FB - 1) begin
                    total++;
                    if (q.size() == 0) begin
                        bad++;
                        $display("FAIL frame%0d: frame received but none expected", frames);
                    end else begin
                        rx_exp = q.pop_front();
                        for (int i = 0; i < NL; i++) rx_got[i*FB +: FB] = {rx[i][FB-1:1], 1'b0};
                        if (rx_got !== rx_exp || err_fr != 0) begin
                            bad++;
                            $display("FAIL frame%0d: got %h exp %h timing_errs=%0d (want 0)",
                                     frames, rx_got, rx_exp, err_fr);
                        end
                    end
                    frames++;
                    err_fr = 0;
                end
                rx_b = (rx_b + 1) % FB;
            end
            rx_pb = bck;
        end
    end

    task automatic send(input logic [DWID-1:0] d);
        int n = 0;
        in_valid = 1; in_data = d;
        while (in_ready !== 1'b1 && n < 4 * FC) begin @(negedge mclk); n++; end
        @(negedge mclk);
        in_valid = 0;
        if (n >= 4 * FC) begin
            total++; bad++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, want 1", in_ready, n);
        end
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (in_ready !== 1'b1 && n < 4 * FC) begin @(negedge mclk); n++; end
        if (n >= 4 * FC) begin
            total++; bad++;
            $display("FAIL %s_ready_timeout: in_ready=%b, want 1", name, in_ready);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (m_run && n < 4 * FC) begin @(negedge mclk); n++; end
        @(negedge mclk);
        total++;
        if (m_run || bck !== 1'b0 || lrck !== 1'b0 || sdata !== '0) begin
            bad++;
            $display("FAIL %s_idle: run=%0b bck=%b lrck=%b sdata=%b, want stopped with all 0",
                     name, m_run, bck, lrck, sdata);
        end
        total++;
        if (q.size() != 0 || err_ctl != 0) begin
            bad++;
            $display("FAIL %s_ctl: queued=%0d ctl_errs=%0d, want 0 and 0", name, q.size(), err_ctl);
        end
    endtask

    task automatic test_reset;
        total++;
        if ({bck, lrck, sdata, underflow} !== '0) begin
            bad++;
            $display("FAIL reset_outs: got %b, want 0", {bck, lrck, sdata, underflow});
        end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b, want 1", in_ready); end
        total++;
        if (underflow_count !== 16'd0) begin
            bad++; $display("FAIL reset_count: got %0d, want 0", underflow_count);
        end
    endtask

    task automatic test_narrow;
        int f0 = frames;
        wide_mode = 0;
        send(mk(24'hA5A5A5, 24'h5A5A5A, 24'h111111));
        enable = 1;
        @(posedge mclk);
        repeat (2 * BD) @(negedge mclk);
        total++;
        if (sdata !== 4'b0000) begin bad++; $display("FAIL narrow_pre_msb: sdata=%b, want 0000", sdata); end
        @(negedge mclk);
        total++;
        if (sdata !== 4'b0001 || lrck !== 1'b0 || bck !== 1'b0) begin
            bad++;
            $display("FAIL narrow_msb: sdata=%b lrck=%b bck=%b, want 0001 0 0", sdata, lrck, bck);
        end
        enable = 0;
        wait_idle("narrow");
        total++;
        if (frames - f0 != 1) begin bad++; $display("FAIL narrow_frames: got %0d, want 1", frames - f0); end
    endtask

    task automatic test_wide;
        int f0 = frames, u0 = obs_uf;
        wide_mode = 1;
        send(mk(24'h100000, 24'h200000, 24'h0));
        enable = 1;
        for (int n = 1; n <= 10; n++) send(mk(24'h100000 + SW'(n), 24'h200000 + SW'(n), 24'h0));
        wait_ready("wide");
        enable = 0;
        wait_idle("wide");
        total++;
        if (frames - f0 != 11) begin bad++; $display("FAIL wide_frames: got %0d, want 11", frames - f0); end
        total++;
        if (obs_uf != u0 || underflow_count !== 16'd0) begin
            bad++;
            $display("FAIL wide_underflow: pulses=%0d count=%0d, want 0 and 0", obs_uf - u0, underflow_count);
        end
    endtask

    task automatic test_underflow;
        int f0 = frames, u0 = obs_uf, n = 0;
        wide_mode = 1;
        send(mk(24'h0ABCDE, 24'h0FEDCB, 24'h010203));
        enable = 1;
        while (m_uf < 3 && n < 6 * FC) begin @(negedge mclk); n++; end
        send(mk(24'h123456, 24'h654321, 24'h001001));
        wait_ready("underflow");
        enable = 0;
        wait_idle("underflow");
        total++;
        if (obs_uf - u0 != 3) begin bad++; $display("FAIL underflow_pulses: got %0d, want 3", obs_uf - u0); end
        total++;
        if (underflow_count !== 16'd3) begin
            bad++; $display("FAIL underflow_count: got %0d, want 3", underflow_count);
        end
        total++;
        if (frames - f0 != 5) begin bad++; $display("FAIL underflow_frames: got %0d, want 5", frames - f0); end
    endtask

    task automatic test_mode_switch;
        int f0 = frames, err = 0;
        wide_mode = 1;
        send(mk(24'hC00001, 24'h300001, 24'h020202));
        enable = 1;
        send(mk(24'hC00002, 24'h300002, 24'h020202));
        repeat (FC / 2) @(negedge mclk);
        wide_mode = 0;
        wait_ready("mode");
        repeat (FC / 2) @(negedge mclk);
        wide_mode = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge mclk);
            if (sdata[NL-1:1] !== '0) err++;
        end
        total++;
        if (err != 0) begin bad++; $display("FAIL mode_narrow_lines: %0d nonzero samples, want 0", err); end
        enable = 0;
        wait_idle("mode");
        total++;
        if (frames - f0 != 2) begin bad++; $display("FAIL mode_frames: got %0d, want 2", frames - f0); end
    endtask

    task automatic test_stop_start;
        int f0 = frames, err = 0;
        wide_mode = 1;
        send(mk(24'h777777, 24'h888888, 24'h000111));
        enable = 1;
        @(posedge mclk);
        repeat (10 * 2 * BD + 1) @(negedge mclk);
        enable = 0;
        send(mk(24'hDEAD01, 24'hBEEF02, 24'h010000));
        wait_idle("stop");
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL stop_hold: in_ready=%b, want 0 (frame held)", in_ready); end
        for (int i = 0; i < 20; i++) begin
            @(negedge mclk);
            if ({bck, lrck, sdata} !== '0) err++;
        end
        total++;
        if (err != 0) begin bad++; $display("FAIL stop_quiet: %0d active samples in idle, want 0", err); end
        enable = 1;
        wait_ready("restart");
        enable = 0;
        wait_idle("restart");
        total++;
        if (frames - f0 != 2) begin bad++; $display("FAIL stop_frames: got %0d, want 2", frames - f0); end
    endtask

    task automatic test_async_reset;
        wide_mode = 1;
        send(mk(24'h13579B, 24'h2468AC, 24'h101010));
        enable = 1;
        send(mk(24'hFEDCBA, 24'h012345, 24'h000303));
        repeat (100) @(negedge mclk);
        @(posedge mclk);
        #2 reset_n = 0;
        #1;
        total++;
        if ({bck, lrck, sdata, underflow} !== '0) begin
            bad++; $display("FAIL areset_outs: got %b, want 0", {bck, lrck, sdata, underflow});
        end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL areset_ready: got %b, want 1", in_ready); end
        total++;
        if (underflow_count !== 16'd0) begin
            bad++; $display("FAIL areset_count: got %0d, want 0", underflow_count);
        end
        enable = 0;
        @(negedge mclk);
        reset_n = 1;
        repeat (10) @(negedge mclk);
        wait_idle("areset");
    endtask

    initial begin
        #1 reset_n = 0;
        repeat (3) @(negedge mclk);
        reset_n = 1;
        @(negedge mclk);
        test_reset;
        test_narrow;
        test_wide;
        test_underflow;
        test_mode_switch;
        test_stop_start;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
